rf_bypass: RTL

RF_BYPASS -- requirements
Module: rf_bypass

---
 rtl/rf_bypass_if.sv | 28 ++
 rtl/rf_bypass.sv | 91 +++++++++
 2 files changed

// File: rtl/rf_bypass_if.sv
// Register-file port bundle: two read ports with busy status, one write-back port,
// one reservation port and the sticky protocol-error flag.
interface rf_bypass_if;
    logic [2:0]  read1RegSel;
    logic [2:0]  read2RegSel;
    logic [15:0] read1Data;
    logic [15:0] read2Data;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData;
    logic        writeEn;
    logic [2:0]  reserveSel;
    logic        reserveEn;
    logic        busy1;
    logic        busy2;
    logic        err;

    modport master (
        output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
               reserveSel, reserveEn,
        input  read1Data, read2Data, busy1, busy2, err
    );

    modport slave (
        input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
               reserveSel, reserveEn,
        output read1Data, read2Data, busy1, busy2, err
    );
endinterface

// File: rtl/rf_bypass.sv
// Two-read/one-write register file with per-register busy scoreboard, optional
// same-cycle write-to-read forwarding and a sticky unreserved-write error flag.
module rf_bypass #(
    parameter int BYPASS = 1,
    parameter int NREG   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    rf_bypass_if.slave  bus
);
    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] rd1_store, rd2_store;
    logic              bz1_store, bz2_store;
    logic              wr_busy;
    logic              wr_hit1, wr_hit2, rsv_hit1, rsv_hit2;

    // Selects beyond NREG read as zero / not busy and are never written.
    always_comb begin
        rd1_store = '0;
        rd2_store = '0;
        bz1_store = 1'b0;
        bz2_store = 1'b0;
        wr_busy   = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (bus.read1RegSel == SEL_W'(i)) begin
                rd1_store = regs_q[i];
                bz1_store = busy_q[i];
            end
            if (bus.read2RegSel == SEL_W'(i)) begin
                rd2_store = regs_q[i];
                bz2_store = busy_q[i];
            end
            if (bus.writeRegSel == SEL_W'(i)) begin
                wr_busy = busy_q[i];
            end
        end
    end

    // Reservation is applied after the write-back clear so a same-index
    // reserve in the write cycle leaves the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        err_d  = err_q;
        for (int i = 0; i < NREG; i++) begin
            if (bus.writeEn && (bus.writeRegSel == SEL_W'(i))) begin
                regs_d[i] = bus.writeData;
                busy_d[i] = 1'b0;
            end
            if (bus.reserveEn && (bus.reserveSel == SEL_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        if (bus.writeEn && !wr_busy) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign wr_hit1  = (BYPASS != 0) && bus.writeEn && (bus.writeRegSel == bus.read1RegSel);
    assign wr_hit2  = (BYPASS != 0) && bus.writeEn && (bus.writeRegSel == bus.read2RegSel);
    assign rsv_hit1 = bus.reserveEn && (bus.reserveSel == bus.read1RegSel);
    assign rsv_hit2 = bus.reserveEn && (bus.reserveSel == bus.read2RegSel);

    // Forwarding is gated by rst_n so outputs read zero throughout reset.
    assign bus.read1Data = !rst_n ? '0 : (wr_hit1 ? bus.writeData : rd1_store);
    assign bus.read2Data = !rst_n ? '0 : (wr_hit2 ? bus.writeData : rd2_store);
    assign bus.busy1     = rst_n && bz1_store && !(wr_hit1 && !rsv_hit1);
    assign bus.busy2     = rst_n && bz2_store && !(wr_hit2 && !rsv_hit2);
    assign bus.err       = err_q;
endmodule
